// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one 256-bit sliding window, streams rk0..rk14 over valid/ready.
// Optional AES_KEY_REV_ORDER_EN: buffer all 15 keys, then stream rk14..rk0 for the inverse cipher.
module aes256_key_expand #(
  parameter int unsigned NR = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done
);

  if (NR != 14) begin : g_nr_check
    $error("aes256_key_expand: NR must be 14 for AES-256");
  end

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_EMIT, S_DONE} state_t;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Forward S-box: GF(2^8) inverse as x^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [255:0]   r_window;
  logic [127:0]   r_rk_data;
  logic [3:0]     r_rk_idx;
  logic [3:0]     w_src_idx;
  logic [3:0]     w_tgt_idx;
  logic [3:0]     w_last_beat;
  logic [31:0]    w_w7_rot;
  logic [31:0]    w_sub_in;
  logic [31:0]    w_sub_out;
  logic [31:0]    w_t;
  logic [7:0]     w_rcon;
  logic [31:0]    w_o0, w_o1, w_o2, w_o3;
  logic [127:0]   w_next_key;
  logic           w_hs;
  logic           w_adv;

`ifdef AES_KEY_REV_ORDER_EN
  logic [3:0]     r_gcnt;
  logic [127:0]   r_buf [0:NR];
  assign w_src_idx   = r_gcnt;
  assign w_adv       = (r_state == S_GEN);
  assign w_last_beat = 4'd0;
`else
  assign w_src_idx   = r_rk_idx;
  assign w_adv       = w_hs && !rk_last;
  assign w_last_beat = LAST_IDX;
`endif

  assign rk_valid = (r_state == S_EMIT);
  assign rk_data  = r_rk_data;
  assign rk_idx   = r_rk_idx;
  assign rk_last  = rk_valid && (r_rk_idx == w_last_beat);
  assign w_hs     = rk_valid && rk_ready;

  // Step from key index w_src_idx to w_tgt_idx; index 1 is just the low half of the cipher key.
  assign w_tgt_idx = w_src_idx + 4'd1;
  assign w_w7_rot  = {r_window[23:0], r_window[31:24]};
  assign w_sub_in  = w_tgt_idx[0] ? r_window[31:0] : w_w7_rot;

  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign w_sub_out[8*g +: 8] = sbox(w_sub_in[8*g +: 8]);
  end

  assign w_rcon = 8'h01 << (w_tgt_idx[3:1] - 3'd1);
  assign w_t    = w_tgt_idx[0] ? w_sub_out : (w_sub_out ^ {w_rcon, 24'h0});
  assign w_o0   = r_window[255:224] ^ w_t;
  assign w_o1   = r_window[223:192] ^ w_o0;
  assign w_o2   = r_window[191:160] ^ w_o1;
  assign w_o3   = r_window[159:128] ^ w_o2;
  assign w_next_key = (w_src_idx == 4'd0) ? r_window[127:0] : {w_o0, w_o1, w_o2, w_o3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef AES_KEY_REV_ORDER_EN
        if (start) w_state_nxt = S_GEN;
`else
        if (start) w_state_nxt = S_EMIT;
`endif
      end
      S_GEN: begin
        busy = 1'b1;
        if (w_src_idx == LAST_IDX - 4'd1) w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        busy = 1'b1;
        if (w_hs && rk_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_window  <= '0;
      r_rk_data <= '0;
      r_rk_idx  <= '0;
`ifdef AES_KEY_REV_ORDER_EN
      r_gcnt    <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && start) begin
        r_window <= key;
`ifdef AES_KEY_REV_ORDER_EN
        r_gcnt   <= '0;
`else
        r_rk_data <= key[255:128];
        r_rk_idx  <= '0;
`endif
      end
      if (w_adv) begin
        if (w_src_idx != 4'd0) r_window <= {r_window[127:0], w_next_key};
`ifdef AES_KEY_REV_ORDER_EN
        r_gcnt <= w_tgt_idx;
        if (w_tgt_idx == LAST_IDX) begin
          r_rk_data <= w_next_key;
          r_rk_idx  <= LAST_IDX;
        end
`else
        r_rk_data <= w_next_key;
        r_rk_idx  <= w_tgt_idx;
`endif
      end
`ifdef AES_KEY_REV_ORDER_EN
      if (w_hs && !rk_last) begin
        r_rk_idx  <= r_rk_idx - 4'd1;
        r_rk_data <= r_buf[r_rk_idx - 4'd1];
      end
`endif
    end
  end

`ifdef AES_KEY_REV_ORDER_EN
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) r_buf[0] <= key[255:128];
    if (w_adv) r_buf[w_tgt_idx] <= w_next_key;
  end
`endif

endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
- Sequential AES-256 key schedule. Generates the 15 128-bit round keys (rk0..rk14) that feed the round datapath (AES_256_roundop).
- Generates one new round key per accepted output beat and streams keys over a valid/ready interface.
- Iterative design: one 256-bit sliding window, 4 forward SubBytes_mix instances (ZF=1) for SubWord. No precomputed key RAM in the default build.

Parameters:
- NR, 14, last round index; fixed for AES-256; any other value is a configuration error (elaboration-time check).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load key and begin expansion; sampled only in IDLE
- key  in  256  cipher key; key[255:224] is w0
- busy  out  1  high from accepted start until last beat handshake
- rk_valid  out  1  round key on rk_data is valid
- rk_ready  in  1  consumer accepts round key
- rk_data  out  128  round key; [127:96] is the first word
- rk_idx  out  4  index of round key on rk_data (0..14)
- rk_last  out  1  high with rk_valid when rk_idx is the final beat
- done  out  1  one-cycle pulse the cycle after the last handshake

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, rk_valid=0, rk_data=0, rk_idx=0, rk_last=0, done=0; window=0. Reset mid-expansion aborts with no done pulse.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 at a clock edge: window<=key, rk_data<=key[255:128], rk_idx<=0, rk_valid<=1, busy<=1, go to EMIT.
  - First key is valid the cycle after start.
- EMIT:
  - Outputs hold stable while rk_valid && !rk_ready.
  - On handshake with rk_idx=0: rk_data<=window[127:0], rk_idx<=1.
  - On handshake with rk_idx=n, 1<=n<=13:
    - next = f(window, n+1); rk_data<=next; window<={window[127:0], next}; rk_idx<=n+1.
- f(window, r), with window words W0..W7 (W0 = MSBs):
  - t = SubWord(RotWord(W7)) ^ {rcon,24'h0} for r even, where rcon = 8'h01 << (r/2 - 1), giving 01,02,04,08,10,20,40.
  - t = SubWord(W7) for r odd.
  - Output words: o0=W0^t, o1=W1^o0, o2=W2^o1, o3=W3^o2.
  - RotWord is a left byte-rotate.
  - All logic is combinational between window and rk_data; one beat per cycle max throughput.
- Handshake at rk_idx=14 (rk_last=1): rk_valid<=0, busy<=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- start while busy or in DONE is ignored; the key is not re-sampled. key may change freely after the start edge.
- rk_last = rk_valid && (rk_idx == 14).

Optional Feature:
- Macro: AES_KEY_REV_ORDER_EN.
- Defined:
  - Adds a 15x128 key buffer. Generation runs internally at one key per cycle regardless of rk_ready; rk_valid stays 0 during generation (14 cycles after start).
  - Once all keys are stored, the buffer streams in order rk14, rk13..rk0. rk_idx reports the true round index, descending.
  - rk_last is set with rk_idx=0. done, busy and reset rules are unchanged.
  - This order serves the inverse cipher (inv_en=1).
- Undefined: no buffer; ascending streaming as above.

Test Plan:
- All tests use key=000102…1e1f.
- Ascending stream, rk_ready=1: start pulse → 15 consecutive beats:
  - rk0=000102030405060708090a0b0c0d0e0f, rk1=101112131415161718191a1b1c1d1e1f, rk2=a573c29fa176c498a97fce93a572c09c, rk14=24fc79ccbf0979e9371ac23c6d68de36
  - rk_last only on beat 14; done pulses the following cycle; busy falls with the last handshake.
- Backpressure: toggle rk_ready randomly and hold it 0 for 5 cycles at rk_idx=7 → rk_data/rk_idx stable while stalled; same 15 values in order, none dropped or duplicated.
- Start while busy: second start with key=all-ones at rk_idx=3 → ignored; rk14 still 24fc79cc…6d68de36.
- Async reset mid-stream: assert rst between edges at rk_idx=9 → all outputs 0 immediately, no done; next start regenerates the full sequence from rk0.
- AES_KEY_REV_ORDER_EN defined: start with rk_ready=1 → rk_valid=0 for 14 cycles, then first beat rk_idx=14 with 24fc79cc…6d68de36 and last beat rk_idx=0 with 00010203…0f, rk_last=1 on that beat.
